// File: rtl/linebuf_pkg.sv
// Shared defaults and helpers for the line-buffer controller.
// Build option: LINEBUF_STATS_EN enables the frame/restart/overflow counters.
package linebuf_pkg;

  localparam int LB_LINES      = 4;
  localparam int LB_LINE_IDX_W = 2;
  localparam int LB_CHAR_W     = 11;
  localparam int STAT_W        = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/linebuf_len_regs.sv
// Per-line committed byte-length storage: one commit write port, one async read port.
module linebuf_len_regs
  import linebuf_pkg::*;
#(
  parameter int LINES = LB_LINES,
  parameter int IDX_W = LB_LINE_IDX_W,
  parameter int LEN_W = LB_CHAR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [LEN_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [LEN_W-1:0] rdata
);

  logic [LEN_W-1:0] mem [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/linebuf_ctrl.sv
// Line-buffer controller: hands free BRAM lines to the writer, commits them with length, releases on rd_done.
// Build option: LINEBUF_STATS_EN adds saturating frame/restart/overflow counters.
module linebuf_ctrl
  import linebuf_pkg::*;
#(
  parameter int LINES      = LB_LINES,
  parameter int LINE_IDX_W = LB_LINE_IDX_W,
  parameter int CHAR_W     = LB_CHAR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_char_incr,
  input  logic                       wr_newline,
  input  logic                       wr_restart_line,
  output logic                       greenflag,
  output logic [LINE_IDX_W+CHAR_W-1:0] wr_addr,
  output logic                       ovf_drop,
  output logic                       rd_valid,
  output logic [LINE_IDX_W-1:0]      rd_line,
  output logic [CHAR_W:0]            rd_len,
  input  logic                       rd_done,
  output logic [STAT_W-1:0]          stat_frames,
  output logic [STAT_W-1:0]          stat_restarts,
  output logic [STAT_W-1:0]          stat_ovf
);

  localparam int USED_W = LINE_IDX_W + 1;
  localparam logic [CHAR_W-1:0] CHAR_MAX = '1;

  logic [LINE_IDX_W-1:0] wr_ptr, rd_ptr;
  logic [USED_W-1:0]     used;
  logic [CHAR_W-1:0]     char_cnt;
  logic                  ovf;
  logic                  ovf_drop_q;

  logic full, accept, restart, newline, incr, commit, discard, rel;
  logic [CHAR_W:0] commit_len;

  // All writer strobes are ignored while every line is occupied.
  always_comb begin
    full    = (used == USED_W'(LINES));
    accept  = !full;
    restart = accept && wr_restart_line;
    newline = accept && wr_newline && !wr_restart_line;
    incr    = accept && wr_char_incr && !wr_newline && !wr_restart_line;
    commit  = newline && !ovf;
    discard = newline && ovf;
    rel     = rd_done && (used != '0);
    commit_len = {1'b0, char_cnt} + (CHAR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      used       <= '0;
      char_cnt   <= '0;
      ovf        <= 1'b0;
      ovf_drop_q <= 1'b0;
    end else begin
      if (restart || newline) begin
        char_cnt <= '0;
        ovf      <= 1'b0;
      end else if (incr) begin
        // Past the line end the count sticks, so extra beats overwrite the last byte.
        if (char_cnt != CHAR_MAX) char_cnt <= char_cnt + CHAR_W'(1);
        else                      ovf      <= 1'b1;
      end
      if (commit) wr_ptr <= wr_ptr + LINE_IDX_W'(1);
      if (rel)    rd_ptr <= rd_ptr + LINE_IDX_W'(1);
      case ({commit, rel})
        2'b10:   used <= used + USED_W'(1);
        2'b01:   used <= used - USED_W'(1);
        default: used <= used;
      endcase
      ovf_drop_q <= discard;
    end
  end

  linebuf_len_regs #(
    .LINES (LINES),
    .IDX_W (LINE_IDX_W),
    .LEN_W (CHAR_W + 1)
  ) u_len_regs (
    .clk   (clk),
    .rst   (rst),
    .we    (commit),
    .waddr (wr_ptr),
    .wdata (commit_len),
    .raddr (rd_ptr),
    .rdata (rd_len)
  );

  assign greenflag = !full;
  assign wr_addr   = {wr_ptr, char_cnt};
  assign ovf_drop  = ovf_drop_q;
  assign rd_valid  = (used != '0);
  assign rd_line   = rd_ptr;

`ifdef LINEBUF_STATS_EN
  logic [STAT_W-1:0] frames_q, restarts_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q   <= '0;
      restarts_q <= '0;
      ovf_q      <= '0;
    end else begin
      if (commit)  frames_q   <= sat_inc(frames_q);
      if (restart) restarts_q <= sat_inc(restarts_q);
      if (discard) ovf_q      <= sat_inc(ovf_q);
    end
  end

  assign stat_frames   = frames_q;
  assign stat_restarts = restarts_q;
  assign stat_ovf      = ovf_q;
`else
  assign stat_frames   = '0;
  assign stat_restarts = '0;
  assign stat_ovf      = '0;
`endif

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Self-checking bench for linebuf_ctrl: queue-based model compared every cycle plus literal checkpoints.
module tb_linebuf_ctrl;

  localparam int LINES    = 4;
  localparam int LINE_SZ  = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_char_incr = 1'b0, wr_newline = 1'b0, wr_restart_line = 1'b0, rd_done = 1'b0;
  logic        greenflag, ovf_drop, rd_valid;
  logic [12:0] wr_addr;
  logic [1:0]  rd_line;
  logic [11:0] rd_len;
  logic [15:0] stat_frames, stat_restarts, stat_ovf;

  int n_pass = 0;
  int n_total = 0;

  linebuf_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .wr_char_incr    (wr_char_incr),
    .wr_newline      (wr_newline),
    .wr_restart_line (wr_restart_line),
    .greenflag       (greenflag),
    .wr_addr         (wr_addr),
    .ovf_drop        (ovf_drop),
    .rd_valid        (rd_valid),
    .rd_line         (rd_line),
    .rd_len          (rd_len),
    .rd_done         (rd_done),
    .stat_frames     (stat_frames),
    .stat_restarts   (stat_restarts),
    .stat_ovf        (stat_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
  endtask

  // Model: pending lines as a FIFO of (line, length); the open frame as a raw beat count.
  int  q_line[$];
  int  q_len[$];
  int  wline = 0;
  int  beats = 0;
  bit  m_drop = 0;
  int  m_frames = 0, m_restarts = 0, m_ovf = 0;
  bit  started = 0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      q_line.delete(); q_len.delete();
      wline = 0; beats = 0; m_drop = 0;
      m_frames = 0; m_restarts = 0; m_ovf = 0;
    end else begin
      bit do_rel;
      do_rel = rd_done && (q_len.size() != 0);
      m_drop = 0;
      if (q_len.size() < LINES) begin
        if (wr_restart_line) begin
          beats = 0;
          if (m_restarts < 65535) m_restarts++;
        end else if (wr_newline) begin
          if (beats < LINE_SZ) begin
            q_line.push_back(wline);
            q_len.push_back(beats + 1);
            wline = (wline + 1) % LINES;
            if (m_frames < 65535) m_frames++;
          end else begin
            m_drop = 1;
            if (m_ovf < 65535) m_ovf++;
          end
          beats = 0;
        end else if (wr_char_incr) begin
          beats++;
        end
      end
      if (do_rel) begin
        void'(q_line.pop_front());
        void'(q_len.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      int lo;
      lo = (beats > LINE_SZ - 1) ? LINE_SZ - 1 : beats;
      chk("greenflag", greenflag, q_len.size() < LINES);
      chk("wr_addr", wr_addr, wline * LINE_SZ + lo);
      chk("rd_valid", rd_valid, q_len.size() != 0);
      if (q_len.size() != 0) begin
        chk("rd_line", rd_line, q_line[0]);
        chk("rd_len", rd_len, q_len[0]);
      end
      chk("ovf_drop", ovf_drop, m_drop);
`ifdef LINEBUF_STATS_EN
      chk("stat_frames", stat_frames, m_frames);
      chk("stat_restarts", stat_restarts, m_restarts);
      chk("stat_ovf", stat_ovf, m_ovf);
`else
      chk("stat_frames", stat_frames, 0);
      chk("stat_restarts", stat_restarts, 0);
      chk("stat_ovf", stat_ovf, 0);
`endif
    end
  end

  task automatic cyc(input logic i, input logic n, input logic r, input logic d);
    wr_char_incr = i; wr_newline = n; wr_restart_line = r; rd_done = d;
    @(posedge clk); #1;
    wr_char_incr = 0; wr_newline = 0; wr_restart_line = 0; rd_done = 0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_greenflag", greenflag, 1);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_wr_addr", wr_addr, 0);

    // 64-byte frame
    repeat (63) cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("f64_rd_valid", rd_valid, 1);
    chk("f64_rd_line", rd_line, 0);
    chk("f64_rd_len", rd_len, 64);
    chk("f64_wr_addr", wr_addr, 13'h800);

    // fill all lines, then a strobe while full is ignored
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    repeat (2) cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    chk("full_greenflag", greenflag, 0);
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    chk("full_ignored_wr_addr", wr_addr, 0);
    chk("full_ignored_rd_line", rd_line, 0);
    cyc(0, 0, 0, 1);
    chk("release_greenflag", greenflag, 1);
    chk("release_rd_line", rd_line, 1);
    chk("release_rd_len", rd_len, 1);
    repeat (3) cyc(0, 0, 0, 1);
    chk("drained_rd_valid", rd_valid, 0);
    cyc(0, 0, 0, 1);

    // restart discards and reuses the line
    repeat (10) cyc(1, 0, 0, 0);
    chk("pre_restart_wr_addr", wr_addr, 13'h00A);
    cyc(0, 0, 1, 0);
    chk("restart_wr_addr", wr_addr, 0);
    chk("restart_rd_valid", rd_valid, 0);
    repeat (4) cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("after_restart_rd_line", rd_line, 0);
    chk("after_restart_rd_len", rd_len, 5);
    cyc(0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    chk("restart_prio_rd_valid", rd_valid, 0);
    chk("restart_prio_wr_addr", wr_addr, 13'h800);

    // oversize frame
    repeat (2099) cyc(1, 0, 0, 0);
    chk("ovf_wr_addr_sat", wr_addr, 13'h0FFF);
    cyc(0, 1, 0, 0);
    chk("ovf_drop_pulse", ovf_drop, 1);
    chk("ovf_rd_valid", rd_valid, 0);
    cyc(0, 0, 0, 0);
    chk("ovf_drop_single", ovf_drop, 0);
    chk("ovf_wr_addr_reset", wr_addr, 13'h800);

    // simultaneous commit and release, wrapping both pointers
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    chk("simul_rd_line", rd_line, 2);
    chk("simul_greenflag", greenflag, 1);
    for (int k = 0; k < 9; k++) begin
      repeat (k) cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 1);
    end
    chk("wrap_rd_line", rd_line, 3);
    chk("wrap_rd_valid", rd_valid, 1);
    chk("wrap_wr_addr", wr_addr, 13'h800);

    // reset mid-frame with three lines in use
    cyc(0, 1, 0, 0);
    repeat (5) cyc(1, 0, 0, 0);
    rst = 1'b1;
    cyc(1, 0, 0, 0);
    rst = 1'b0;
    chk("rst_greenflag", greenflag, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_stat_frames", stat_frames, 0);
    chk("rst_ovf_drop", ovf_drop, 0);

`ifdef LINEBUF_STATS_EN
    cyc(0, 1, 0, 0);
    repeat (69999) cyc(0, 1, 0, 1);
    chk("stat_frames_sat", stat_frames, 16'hFFFF);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
